a2d_sched: RTL and testbench

//  Sequences the shared SPI A2D converter on behalf of the digital core. Each nxt

---
 rtl/a2d_sched_if.sv | 11 +
 rtl/a2d_sched.sv | 199 +++++++++++++++++++
 tb/tb_a2d_sched.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a2d_sched_if.sv
// SPI master handshake bundle between a2d_sched (master) and the generic SPI
// master block (slave): start pulse and transmit word out, completion and received word back.
interface a2d_sched_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;

  modport master (output wrt, output cmd, input done, input resp);
  modport slave  (input wrt, input cmd, output done, output resp);
endinterface

// File: rtl/a2d_sched.sv
// A2D scan sequencer: each nxt rising edge runs a command+read SPI pair for the
// left, right and battery channels. Optional overrun reporting under A2D_OVRN_EN.
module a2d_sched #(
  parameter logic [2:0]  LFT_CHNL  = 3'd0,
  parameter logic [2:0]  RGHT_CHNL = 3'd4,
  parameter logic [2:0]  BATT_CHNL = 3'd5,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          nxt_i,
  a2d_sched_if.master   spi,
  output logic [11:0]   lft_ld_o,
  output logic [11:0]   rght_ld_o,
  output logic [11:0]   batt_o,
  output logic          scan_vld_o,
  output logic          busy_o
`ifdef A2D_OVRN_EN
  ,
  input  logic          ovrn_clr_i,
  output logic          ovrn_o,
  output logic [7:0]    ovrn_cnt_o
`endif
);

  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WCMD, S_GAP1, S_RD, S_WRD, S_GAP2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          pending_q, pending_d;
  logic          busy_q, busy_d;
  logic          scan_vld_q, scan_vld_d;
  logic [11:0]   lft_q, lft_d, rght_q, rght_d, batt_q, batt_d;
  logic          nxt_q;
  logic          req;
  logic          drop;

  function automatic logic [15:0] cmd_word(input logic [1:0] idx);
    logic [2:0] chnl;
    case (idx)
      2'd1:    chnl = RGHT_CHNL;
      2'd2:    chnl = BATT_CHNL;
      default: chnl = LFT_CHNL;
    endcase
    return {2'b00, chnl, 11'h000};
  endfunction

  assign req = nxt_i & ~nxt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      cmd_q      <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      scan_vld_q <= 1'b0;
      lft_q      <= '0;
      rght_q     <= '0;
      batt_q     <= '0;
      nxt_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      cmd_q      <= cmd_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      scan_vld_q <= scan_vld_d;
      lft_q      <= lft_d;
      rght_q     <= rght_d;
      batt_q     <= batt_d;
      nxt_q      <= nxt_i;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    cmd_d      = cmd_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    scan_vld_d = 1'b0;
    lft_d      = lft_q;
    rght_d     = rght_q;
    batt_d     = batt_q;
    spi.wrt    = 1'b0;
    drop       = 1'b0;

    // Requests arriving mid-scan queue one deep; anything beyond is dropped.
    if (req && (state_q != S_IDLE)) begin
      if (pending_q) drop = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req || pending_q) begin
          state_d   = S_CMD;
          busy_d    = 1'b1;
          pending_d = 1'b0;
          idx_d     = 2'd0;
          cmd_d     = cmd_word(2'd0);
        end
      end
      S_CMD: begin
        spi.wrt = 1'b1;
        state_d = S_WCMD;
      end
      S_WCMD: begin
        if (spi.done) begin
          state_d = S_GAP1;
          gap_d   = GAP_LD;
        end
      end
      S_GAP1: begin
        if (gap_q == '0) state_d = S_RD;
        else             gap_d   = gap_q - GW'(1);
      end
      S_RD: begin
        spi.wrt = 1'b1;
        state_d = S_WRD;
      end
      S_WRD: begin
        if (spi.done) begin
          case (idx_q)
            2'd0:    lft_d  = spi.resp[11:0];
            2'd1:    rght_d = spi.resp[11:0];
            default: batt_d = spi.resp[11:0];
          endcase
          state_d = S_GAP2;
          gap_d   = GAP_LD;
        end
      end
      S_GAP2: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (idx_q == 2'd2) begin
          scan_vld_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          idx_d   = idx_q + 2'd1;
          cmd_d   = cmd_word(idx_q + 2'd1);
          state_d = S_CMD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign spi.cmd    = cmd_q;
  assign lft_ld_o   = lft_q;
  assign rght_ld_o  = rght_q;
  assign batt_o     = batt_q;
  assign scan_vld_o = scan_vld_q;
  assign busy_o     = busy_q;

  logic unused_resp_hi;
  assign unused_resp_hi = ^spi.resp[15:12];

`ifdef A2D_OVRN_EN
  logic       ovrn_q;
  logic [7:0] ovrn_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovrn_q     <= 1'b0;
      ovrn_cnt_q <= '0;
    end else if (ovrn_clr_i) begin
      ovrn_q     <= 1'b0;
      ovrn_cnt_q <= '0;
    end else if (drop) begin
      ovrn_q     <= 1'b1;
      ovrn_cnt_q <= (ovrn_cnt_q == 8'hFF) ? 8'hFF : ovrn_cnt_q + 8'd1;
    end
  end

  assign ovrn_o     = ovrn_q;
  assign ovrn_cnt_o = ovrn_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched: a small SPI slave model answers each transaction
// after a fixed latency and logs wrt/done/scan_vld timing for the checks.
module tb_a2d_sched;

  localparam int SPI_LAT = 3;
  localparam int LOGN    = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nxt;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        scan_vld, busy;
`ifdef A2D_OVRN_EN
  logic        ovrn_clr;
  logic        ovrn;
  logic [7:0]  ovrn_cnt;
`endif

  a2d_sched_if spi_if ();

  a2d_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .nxt_i      (nxt),
    .spi        (spi_if.master),
    .lft_ld_o   (lft_ld),
    .rght_ld_o  (rght_ld),
    .batt_o     (batt),
    .scan_vld_o (scan_vld),
    .busy_o     (busy)
`ifdef A2D_OVRN_EN
    ,
    .ovrn_clr_i (ovrn_clr),
    .ovrn_o     (ovrn),
    .ovrn_cnt_o (ovrn_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave model state and event logs, all owned by the negedge process.
  int          cyc = 0;
  int          n_wrt = 0, n_done = 0, n_vld = 0, n_overlap = 0;
  int          wrt_cyc [LOGN];
  logic [15:0] wrt_cmd [LOGN];
  int          done_cyc[LOGN];
  int          vld_cyc [LOGN];
  logic        vld_busy;
  logic        outstanding = 1'b0;
  logic        tx_par = 1'b0, cur_rd = 1'b0;
  int          lat = 0;

  // Written by the stimulus process only.
  logic        inject_done = 1'b0;
  logic [15:0] lft_val, rght_val, batt_val;

  function automatic logic [15:0] rd_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return lft_val;
      3'd4:    return rght_val;
      3'd5:    return batt_val;
      default: return 16'h0BAD;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      spi_if.done = 1'b0;
      spi_if.resp = 16'h0000;
      outstanding = 1'b0;
      tx_par      = 1'b0;
    end else begin
      if (spi_if.wrt) begin
        if (n_wrt < LOGN) begin
          wrt_cyc[n_wrt] = cyc;
          wrt_cmd[n_wrt] = spi_if.cmd;
        end
        n_wrt++;
      end
      if (scan_vld) begin
        if (n_vld < LOGN) vld_cyc[n_vld] = cyc;
        vld_busy = busy;
        n_vld++;
      end
      spi_if.done = 1'b0;
      if (outstanding) begin
        if (lat == 0) begin
          spi_if.done = 1'b1;
          // Command-phase replies carry junk that must never reach a result.
          spi_if.resp = cur_rd ? rd_val(spi_if.cmd[13:11]) : 16'h0EEE;
          outstanding = 1'b0;
          if (n_done < LOGN) done_cyc[n_done] = cyc;
          n_done++;
        end else begin
          lat--;
        end
      end else if (inject_done) begin
        spi_if.done = 1'b1;
        spi_if.resp = 16'h0777;
      end
      if (spi_if.wrt) begin
        if (outstanding) n_overlap++;
        outstanding = 1'b1;
        lat         = SPI_LAT;
        cur_rd      = tx_par;
        tx_par      = ~tx_par;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_nxt();
    nxt = 1'b1;
    step(1);
    nxt = 1'b0;
    step(1);
  endtask

  task automatic wait_vld(input int target, input int limit, input string tag);
    int k = 0;
    while (n_vld < target && k < limit) begin
      step(1);
      k++;
    end
    check(tag, 32'(n_vld >= target), 32'd1);
  endtask

  int bw, bd, bv;

  initial begin
    rst_n    = 1'b0;
    nxt      = 1'b0;
    lft_val  = 16'h0ABC;
    rght_val = 16'h0123;
    batt_val = 16'h0FFF;
`ifdef A2D_OVRN_EN
    ovrn_clr = 1'b0;
`endif
    step(3);

    // Reset state
    check("rst_wrt",  32'(spi_if.wrt), 32'd0);
    check("rst_cmd",  32'(spi_if.cmd), 32'h0000);
    check("rst_lft",  32'(lft_ld),     32'h000);
    check("rst_rght", 32'(rght_ld),    32'h000);
    check("rst_batt", 32'(batt),       32'h000);
    check("rst_vld",  32'(scan_vld),   32'd0);
    check("rst_busy", 32'(busy),       32'd0);
`ifdef A2D_OVRN_EN
    check("rst_ovrn",     32'(ovrn),     32'd0);
    check("rst_ovrn_cnt", 32'(ovrn_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    step(2);

    // Single scan: command words, results, gap timing
    bw = n_wrt; bd = n_done; bv = n_vld;
    pulse_nxt();
    check("busy_mid", 32'(busy), 32'd1);
    wait_vld(bv + 1, 400, "scan1_timeout");
    step(20);
    check("scan1_wrt_cnt", 32'(n_wrt - bw), 32'd6);
    check("cmd0", 32'(wrt_cmd[bw+0]), 32'h0000);
    check("cmd1", 32'(wrt_cmd[bw+1]), 32'h0000);
    check("cmd2", 32'(wrt_cmd[bw+2]), 32'h2000);
    check("cmd3", 32'(wrt_cmd[bw+3]), 32'h2000);
    check("cmd4", 32'(wrt_cmd[bw+4]), 32'h2800);
    check("cmd5", 32'(wrt_cmd[bw+5]), 32'h2800);
    check("scan1_lft",  32'(lft_ld),  32'hABC);
    check("scan1_rght", 32'(rght_ld), 32'h123);
    check("scan1_batt", 32'(batt),    32'hFFF);
    check("scan1_vld_cnt", 32'(n_vld - bv), 32'd1);
    check("busy_falls_with_vld", 32'(vld_busy), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    for (int k = 1; k < 6; k++)
      check($sformatf("gap%0d", k), 32'(wrt_cyc[bw+k] - done_cyc[bd+k-1]), 32'd5);

    // Second request queues, third and fourth are dropped
    lft_val = 16'h0111; rght_val = 16'h0222; batt_val = 16'h0333;
    bw = n_wrt; bv = n_vld;
    pulse_nxt();
    step(8);
    pulse_nxt();
    step(4);
    pulse_nxt();
    step(4);
    pulse_nxt();
    wait_vld(bv + 2, 400, "scan2_timeout");
    step(150);
    check("pend_vld_cnt", 32'(n_vld - bv), 32'd2);
    check("pend_wrt_cnt", 32'(n_wrt - bw), 32'd12);
    check("pend_start",   32'(wrt_cyc[bw+6] - vld_cyc[bv]), 32'd1);
    check("pend_lft",  32'(lft_ld),  32'h111);
    check("pend_batt", 32'(batt),    32'h333);
`ifdef A2D_OVRN_EN
    check("ovrn_set", 32'(ovrn),     32'd1);
    check("ovrn_cnt", 32'(ovrn_cnt), 32'd2);
    ovrn_clr = 1'b1;
    step(1);
    ovrn_clr = 1'b0;
    check("ovrn_clr",     32'(ovrn),     32'd0);
    check("ovrn_cnt_clr", 32'(ovrn_cnt), 32'd0);
`endif

    // Level held high gives one scan only
    lft_val = 16'h0AAA; rght_val = 16'h0BBB; batt_val = 16'h0CCC;
    bv = n_vld;
    nxt = 1'b1;
    step(500);
    nxt = 1'b0;
    step(100);
    check("level_vld_cnt", 32'(n_vld - bv), 32'd1);
    check("level_rght", 32'(rght_ld), 32'hBBB);

    // Async reset during the battery read
    batt_val = 16'h0555;
    bw = n_wrt;
    pulse_nxt();
    for (int k = 0; k < 300 && n_wrt < bw + 6; k++) step(1);
    check("reach_batt_rd", 32'(n_wrt - bw), 32'd6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_lft",  32'(lft_ld),     32'h000);
    check("mid_rst_rght", 32'(rght_ld),    32'h000);
    check("mid_rst_batt", 32'(batt),       32'h000);
    check("mid_rst_busy", 32'(busy),       32'd0);
    check("mid_rst_wrt",  32'(spi_if.wrt), 32'd0);
    check("mid_rst_cmd",  32'(spi_if.cmd), 32'h0000);
    step(2);
    rst_n = 1'b1;
    bw = n_wrt;
    step(50);
    check("no_wrt_after_rst", 32'(n_wrt - bw), 32'd0);

    // Stray done in IDLE
    bw = n_wrt;
    inject_done = 1'b1;
    step(1);
    inject_done = 1'b0;
    step(5);
    check("stray_idle_lft",  32'(lft_ld), 32'h000);
    check("stray_idle_busy", 32'(busy),   32'd0);
    check("stray_idle_wrt",  32'(n_wrt - bw), 32'd0);

    // Stray done in GAP1
    lft_val = 16'h0456; rght_val = 16'h0789; batt_val = 16'h0321;
    bw = n_wrt; bd = n_done; bv = n_vld;
    pulse_nxt();
    for (int k = 0; k < 100 && n_done == bd; k++) step(1);
    inject_done = 1'b1;
    step(1);
    inject_done = 1'b0;
    wait_vld(bv + 1, 400, "scan_stray_timeout");
    step(10);
    check("stray_gap_timing", 32'(wrt_cyc[bw+1] - done_cyc[bd]), 32'd5);
    check("stray_gap_wrt",    32'(n_wrt - bw), 32'd6);
    check("stray_gap_lft",    32'(lft_ld),  32'h456);
    check("stray_gap_rght",   32'(rght_ld), 32'h789);
    check("stray_gap_batt",   32'(batt),    32'h321);

    check("no_wrt_overlap", 32'(n_overlap), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
